// File: rtl/cmul_conj_pipe.sv
// Two-stage registered conjugate multiply: out = a * conj(b), full precision.
// Stage 2 registers the four partial products, stage 3 the combined re/im.
module cmul_conj_pipe #(
   parameter int WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       en,
   input  logic                       in_valid,
   input  logic [2*WIDTH-1:0]         in_a,
   input  logic [2*WIDTH-1:0]         in_b,
   input  logic                       in_last,
   output logic                       out_valid,
   output logic [2*(2*WIDTH+1)-1:0]   out_data,
   output logic                       out_last
);
   localparam int PW     = 2 * WIDTH;
   localparam int OWIDTH = 2 * WIDTH + 1;

   logic signed [WIDTH-1:0]  a_i, a_q, b_i, b_q;
   logic signed [PW-1:0]     p_ii_reg, p_qq_reg, p_qi_reg, p_iq_reg;
   logic                     s2_valid_reg, s2_last_reg;
   logic signed [OWIDTH-1:0] re_next, im_next;
   logic signed [OWIDTH-1:0] re_reg, im_reg;
   logic                     s3_valid_reg, s3_last_reg;

   assign a_i = in_a[2*WIDTH-1:WIDTH];
   assign a_q = in_a[WIDTH-1:0];
   assign b_i = in_b[2*WIDTH-1:WIDTH];
   assign b_q = in_b[WIDTH-1:0];

   // One extra bit absorbs the (-2^(W-1))^2 * 2 corner without wrapping.
   assign re_next = {p_ii_reg[PW-1], p_ii_reg} + {p_qq_reg[PW-1], p_qq_reg};
   assign im_next = {p_qi_reg[PW-1], p_qi_reg} - {p_iq_reg[PW-1], p_iq_reg};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         p_ii_reg     <= '0;
         p_qq_reg     <= '0;
         p_qi_reg     <= '0;
         p_iq_reg     <= '0;
         s2_valid_reg <= 1'b0;
         s2_last_reg  <= 1'b0;
         re_reg       <= '0;
         im_reg       <= '0;
         s3_valid_reg <= 1'b0;
         s3_last_reg  <= 1'b0;
      end else begin
         if (en) begin
            p_ii_reg    <= a_i * b_i;
            p_qq_reg    <= a_q * b_q;
            p_qi_reg    <= a_q * b_i;
            p_iq_reg    <= a_i * b_q;
            s2_last_reg <= in_last;
            re_reg      <= re_next;
            im_reg      <= im_next;
            s3_last_reg <= s2_last_reg;
         end
         if (flush) begin
            s2_valid_reg <= 1'b0;
            s3_valid_reg <= 1'b0;
         end else if (en) begin
            s2_valid_reg <= in_valid;
            s3_valid_reg <= s2_valid_reg;
         end
      end
   end

   assign out_valid = s3_valid_reg;
   assign out_data  = {re_reg, im_reg};
   assign out_last  = s3_last_reg;
endmodule

// File: rtl/delay_conj_mult.sv
// Conjugate lag product y[n] = x[n] * conj(x[n-D]) on an AXI-Stream of complex samples.
// Holds the circular delay buffer and priming counter; the multiply lives in cmul_conj_pipe.
module delay_conj_mult #(
   parameter int WIDTH     = 16,
   parameter int MAX_DELAY = 64
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               clear,
   input  logic [$clog2(MAX_DELAY+1)-1:0]     delay,
   input  logic [2*WIDTH-1:0]                 i_tdata,
   input  logic                               i_tlast,
   input  logic                               i_tvalid,
   output logic                               i_tready,
   output logic [2*(2*WIDTH+1)-1:0]           o_tdata,
   output logic                               o_tlast,
   output logic                               o_tvalid,
   input  logic                               o_tready
);
   localparam int OWIDTH = 2 * WIDTH + 1;
   localparam int AW     = $clog2(MAX_DELAY);
   localparam int DW     = $clog2(MAX_DELAY + 1);

   logic                 en, accept;
   logic                 load_pending_reg;
   logic [DW-1:0]        d_r_reg, d_eff;
   logic [AW-1:0]        wp_reg, rd_addr;
   logic [DW-1:0]        fc_reg;
   logic                 priming, bypass;

   logic [2*WIDTH-1:0]   mem [MAX_DELAY];
   logic [2*WIDTH-1:0]   rd_data_reg;

   logic                 s1_valid_reg, s1_last_reg, s1_prime_reg, s1_bypass_reg;
   logic [2*WIDTH-1:0]   s1_a_reg, s1_b;

   logic                 pipe_valid, pipe_last;
   logic [2*OWIDTH-1:0]  pipe_data;

   assign en       = o_tready | ~o_tvalid;
   assign i_tready = en & ~clear;
   assign accept   = i_tvalid & i_tready;

   // The beat accepted on the first clock after reset already sees the new lag.
   assign d_eff    = load_pending_reg ? delay : d_r_reg;
   assign priming  = fc_reg < d_eff;
   assign bypass   = (d_eff == '0);
   // D = MAX_DELAY truncates to 0, landing on the slot about to be overwritten.
   assign rd_addr  = wp_reg - d_eff[AW-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         load_pending_reg <= 1'b1;
         d_r_reg          <= '0;
         wp_reg           <= '0;
         fc_reg           <= '0;
      end else begin
         load_pending_reg <= 1'b0;
         if (clear) begin
            d_r_reg <= delay;
            wp_reg  <= '0;
            fc_reg  <= '0;
         end else begin
            if (load_pending_reg)
               d_r_reg <= delay;
            if (accept) begin
               wp_reg <= wp_reg + AW'(1);
               if (priming)
                  fc_reg <= fc_reg + DW'(1);
            end
         end
      end
   end

   // Buffer contents are never cleared; fc_reg alone decides which reads are valid.
   always_ff @(posedge clk) begin
      if (accept) begin
         rd_data_reg  <= mem[rd_addr];
         mem[wp_reg]  <= i_tdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_reg  <= 1'b0;
         s1_last_reg   <= 1'b0;
         s1_prime_reg  <= 1'b0;
         s1_bypass_reg <= 1'b0;
         s1_a_reg      <= '0;
      end else begin
         if (clear)
            s1_valid_reg <= 1'b0;
         else if (en)
            s1_valid_reg <= accept;
         if (accept) begin
            s1_a_reg      <= i_tdata;
            s1_last_reg   <= i_tlast;
            s1_prime_reg  <= priming;
            s1_bypass_reg <= bypass;
         end
      end
   end

   assign s1_b = s1_prime_reg  ? '0       :
                 s1_bypass_reg ? s1_a_reg : rd_data_reg;

   cmul_conj_pipe #(
      .WIDTH (WIDTH)
   ) u_cmul (
      .clk       (clk),
      .reset     (reset),
      .flush     (clear),
      .en        (en),
      .in_valid  (s1_valid_reg),
      .in_a      (s1_a_reg),
      .in_b      (s1_b),
      .in_last   (s1_last_reg),
      .out_valid (pipe_valid),
      .out_data  (pipe_data),
      .out_last  (pipe_last)
   );

   assign o_tvalid = pipe_valid;
   assign o_tdata  = pipe_data;
   assign o_tlast  = pipe_last;
endmodule

// File: tb/tb_delay_conj_mult.sv
// Bench for delay_conj_mult: directed steps plus random backpressure against a
// history-based model of y[n] = x[n] * conj(x[n-D]).
module tb_delay_conj_mult;
   localparam int WIDTH     = 16;
   localparam int MAX_DELAY = 64;

   logic        clk = 1'b0;
   logic        reset;
   logic        clear;
   logic [6:0]  delay;
   logic [31:0] i_tdata;
   logic        i_tlast;
   logic        i_tvalid;
   logic        i_tready;
   logic [65:0] o_tdata;
   logic        o_tlast;
   logic        o_tvalid;
   logic        o_tready;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [31:0] hist  [$];
   logic [66:0] exp_q [$];
   logic [65:0] obs_q [$];
   int          acc_cyc_q [$];
   int          out_cyc_q [$];
   int          d_model;
   bit          stall_prev;
   logic [65:0] held_data;
   logic        held_last;

   delay_conj_mult #(.WIDTH(WIDTH), .MAX_DELAY(MAX_DELAY)) dut (
      .clk(clk), .reset(reset), .clear(clear), .delay(delay),
      .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
      .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [65:0] mk(input longint re, input longint im);
      return {re[32:0], im[32:0]};
   endfunction

   function automatic logic [65:0] cj(input logic [31:0] a, input logic [31:0] b);
      longint ai, aq, bi, bq;
      ai = longint'($signed(a[31:16]));
      aq = longint'($signed(a[15:0]));
      bi = longint'($signed(b[31:16]));
      bq = longint'($signed(b[15:0]));
      return mk(ai * bi + aq * bq, aq * bi - ai * bq);
   endfunction

   task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Monitor and reference model, sampled on the falling edge.
   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         hist.delete();
         d_model    = int'(delay);
         stall_prev = 1'b0;
      end else begin
         if (stall_prev)
            chk("stall_hold", {o_tvalid, o_tlast, o_tdata}, {1'b1, held_last, held_data});
         if (o_tvalid && o_tready && !clear) begin
            checks++;
            assert (exp_q.size() != 0) else begin
               errors++;
               $error("FAIL unexpected_beat observed=%h expected=none", o_tdata);
            end
            if (exp_q.size() != 0)
               chk("beat", {o_tlast, o_tdata}, exp_q.pop_front());
            $display("beat cyc=%0d data=%h last=%0b", cyc, o_tdata, o_tlast);
            obs_q.push_back(o_tdata);
            out_cyc_q.push_back(cyc);
         end
         if (i_tvalid && i_tready) begin
            logic [31:0] b;
            int n;
            n = hist.size();
            hist.push_back(i_tdata);
            b = (n >= d_model) ? hist[n - d_model] : 32'd0;
            exp_q.push_back({i_tlast, cj(i_tdata, b)});
            acc_cyc_q.push_back(cyc);
         end
         if (clear) begin
            exp_q.delete();
            hist.delete();
            d_model = int'(delay);
         end
         stall_prev = o_tvalid && !o_tready && !clear;
         held_data  = o_tdata;
         held_last  = o_tlast;
      end
   end

   task automatic send(input logic [31:0] x, input logic last);
      bit ok;
      int k;
      i_tdata  = x;
      i_tlast  = last;
      i_tvalid = 1'b1;
      ok = 1'b0;
      k  = 0;
      while (!ok && k < 200) begin
         @(negedge clk);
         ok = i_tready;
         @(posedge clk);
         #1;
         k++;
      end
      if (!ok) chk("send_timeout", {66'd0, ok}, 67'd1);
      i_tvalid = 1'b0;
   endtask

   task automatic drain();
      int k;
      i_tvalid = 1'b0;
      o_tready = 1'b1;
      k = 0;
      while ((exp_q.size() != 0 || o_tvalid) && k < 100) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("drain", 67'(exp_q.size()), 67'd0);
   endtask

   task automatic do_clear(input int d);
      delay = 7'(d);
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
   endtask

   task automatic reset_obs();
      obs_q.delete();
      acc_cyc_q.delete();
      out_cyc_q.delete();
   endtask

   initial begin
      logic [31:0] xs [6];
      bit done;
      int lo;

      reset = 1'b1; clear = 1'b0; delay = 7'd2;
      i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0; o_tready = 1'b1;
      stall_prev = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_tvalid", {66'd0, o_tvalid}, 67'd0);
      chk("rst_tlast",  {66'd0, o_tlast},  67'd0);
      chk("rst_tdata",  {1'b0, o_tdata},   67'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // D=2 directed with latency
      reset_obs();
      send({16'd1, 16'd2}, 1'b0);
      send({16'd3, 16'd4}, 1'b0);
      send({16'd5, 16'd6}, 1'b0);
      send({16'd7, 16'd8}, 1'b1);
      drain();
      chk("d2_count", 67'(obs_q.size()), 67'd4);
      chk("d2_y0", {1'b0, obs_q[0]}, {1'b0, mk(0, 0)});
      chk("d2_y1", {1'b0, obs_q[1]}, {1'b0, mk(0, 0)});
      chk("d2_y2", {1'b0, obs_q[2]}, {1'b0, mk(17, -4)});
      chk("d2_y3", {1'b0, obs_q[3]}, {1'b0, mk(53, -4)});
      chk("latency", 67'(out_cyc_q[0] - acc_cyc_q[0]), 67'd3);

      // D=0 bypass, including the most negative corner
      do_clear(0);
      reset_obs();
      send({16'd3, 16'd4}, 1'b0);
      send(32'h8000_8000, 1'b0);
      drain();
      chk("d0_mag", {1'b0, obs_q[0]}, {1'b0, mk(25, 0)});
      chk("d0_corner", {1'b0, obs_q[1]}, {1'b0, mk(64'sd2147483648, 0)});

      // D=MAX_DELAY ramp
      do_clear(MAX_DELAY);
      reset_obs();
      for (int n = 1; n <= 70; n++) send({16'(n), 16'd0}, 1'b0);
      drain();
      chk("dmax_count", 67'(obs_q.size()), 67'd70);
      chk("dmax_prime", {1'b0, obs_q[63]}, {1'b0, mk(0, 0)});
      chk("dmax_first", {1'b0, obs_q[64]}, {1'b0, mk(65, 0)});

      // D=1 random flow with backpressure bursts
      do_clear(1);
      reset_obs();
      done = 1'b0;
      lo = 0;
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               if ($urandom_range(3) == 0) begin
                  repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
               end
               send($urandom, 1'($urandom_range(1)));
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               if (lo > 0) begin
                  o_tready = 1'b0;
                  lo--;
               end else if ($urandom_range(7) == 0) begin
                  o_tready = 1'b0;
                  lo = 9;
               end else begin
                  o_tready = 1'b1;
               end
            end
         end
      join
      drain();
      chk("bp_count", 67'(obs_q.size()), 67'd1000);

      // Clear mid-stream with delay changed 2 -> 3
      do_clear(2);
      for (int i = 0; i < 6; i++) send($urandom, 1'b0);
      do_clear(3);
      chk("clear_flush", {66'd0, o_tvalid}, 67'd0);
      reset_obs();
      for (int i = 0; i < 5; i++) begin
         xs[i % 6] = $urandom;
         send(xs[i % 6], 1'b0);
      end
      drain();
      chk("clr_count", 67'(obs_q.size()), 67'd5);
      chk("clr_y0", {1'b0, obs_q[0]}, 67'd0);
      chk("clr_y2", {1'b0, obs_q[2]}, 67'd0);
      chk("clr_y3", {1'b0, obs_q[3]}, {1'b0, cj(xs[3], xs[0])});

      // Asynchronous reset mid-burst, restart with D=1
      for (int i = 0; i < 5; i++) send($urandom, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_tvalid", {66'd0, o_tvalid}, 67'd0);
      chk("arst_tdata",  {1'b0, o_tdata},   67'd0);
      delay = 7'd1;
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      chk("arst_idle", {66'd0, o_tvalid}, 67'd0);
      reset_obs();
      for (int i = 0; i < 4; i++) begin
         xs[i] = $urandom;
         send(xs[i], 1'b0);
      end
      drain();
      chk("arst_count", 67'(obs_q.size()), 67'd4);
      chk("arst_y0", {1'b0, obs_q[0]}, 67'd0);
      chk("arst_y1", {1'b0, obs_q[1]}, {1'b0, cj(xs[1], xs[0])});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
